// File: rtl/csd_serial_scaler_16bit_pkg.sv
// Shared definitions for the bit-serial fractional constant multiplier:
// FSM encoding, default widths and the single shift-add step as a function.
package csd_serial_scaler_16bit_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int COEF_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One iteration: (acc + (en ? x : 0)) >>> 1, computed one bit wider so it cannot overflow.
  function automatic logic [WIDTH_DEF-1:0] sra1_add(
    input logic [WIDTH_DEF-1:0] acc,
    input logic [WIDTH_DEF-1:0] x,
    input logic                 en
  );
    logic [WIDTH_DEF:0] sum;
    sum = {acc[WIDTH_DEF-1], acc} + ({(WIDTH_DEF+1){en}} & {x[WIDTH_DEF-1], x});
    return sum[WIDTH_DEF:1];
  endfunction

endpackage

// File: rtl/csd_serial_scaler_16bit_serial_shift_add_step.sv
// Combinational WIDTH+1 bit add of the sign-extended operands followed by an
// arithmetic right shift by one; the per-cycle step of the serial multiplier.
module serial_shift_add_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic             en,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH:0] sum;

  // Since |acc| <= |x|, the extra top bit always holds the true sign of the sum.
  assign sum    = {acc[WIDTH-1], acc} + ({(WIDTH+1){en}} & {x[WIDTH-1], x});
  assign result = sum[WIDTH:1];

endmodule

// File: rtl/csd_serial_scaler_16bit.sv
// Bit-serial fractional scaler: out = floor(in * coef / 2^COEF_BITS), one
// coefficient bit per cycle (LSB first), behind a valid/ready handshake.
module csd_serial_scaler_16bit
  import csd_serial_scaler_16bit_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int COEF_BITS = COEF_BITS_DEF,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in,
  input  logic [COEF_BITS-1:0] coef,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     x_q;
  logic [COEF_BITS-1:0] c_q;
  logic [WIDTH-1:0]     acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     step_result;
  logic                 accept;
  logic                 last_step;

  assign accept    = (state_q == ST_IDLE) && in_valid;
  assign last_step = (cnt_q == CNT_W'(COEF_BITS - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default first, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  serial_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc_q),
    .x      (x_q),
    .en     (c_q[0]),
    .result (step_result)
  );

  // The coefficient is shifted right each step, so c_q[0] is always the bit for the current count.
  // NOTE: datapath registers are reset too, because out is driven straight from acc_q and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      c_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      x_q   <= in;
      c_q   <= coef;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q <= step_result;
      c_q   <= c_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign out       = acc_q;

endmodule

// File: tb/tb_csd_serial_scaler_16bit.sv
// Self-checking bench: directed corner cases plus random samples against an
// integer floor(x*coef/256) model, with backpressure and reset-during-run.
module tb_csd_serial_scaler_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in = '0;
  logic [7:0]  coef = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  csd_serial_scaler_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .coef      (coef),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input logic [7:0] c);
    int p;
    p = int'($signed(x)) * int'(c);
    return 16'(p >>> 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one sample, check latency and result, hold backpressure, then consume.
  task automatic run_one(input logic [15:0] x, input logic [7:0] c, input int hold);
    logic [15:0] e;
    int          n;
    e = model(x, c);
    check("accept_ready", 32'(in_ready), 32'd1);
    in = x; coef = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in = 16'($urandom); coef = 8'($urandom);
    n = 1;
    while (!out_valid && n < 20) begin
      check("busy_run", 32'(busy), 32'd1);
      check("ready_run", 32'(in_ready), 32'd0);
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd9);
    if (!out_valid) return;
    check("result", 32'(out), 32'(e));
    check("ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in = 16'($urandom); coef = 8'($urandom);
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_out", 32'(out), 32'(e));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consumed_valid", 32'(out_valid), 32'd0);
    check("consumed_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    run_one(16'h4000, 8'h80, 0);
    check("dir_4000", 32'(model(16'h4000, 8'h80)), 32'h2000);
    run_one(16'h7FFF, 8'hFF, 0);
    run_one(16'h8000, 8'h80, 0);
    run_one(16'hFFFF, 8'hFF, 0);
    run_one(16'h1234, 8'h00, 0);
    run_one(16'h8000, 8'hFF, 2);
    run_one(16'h5A5A, 8'hC3, 5);
    run_one(16'hA5A5, 8'h01, 1);

    // Reset in the 4th RUN cycle discards the computation.
    in = 16'h3333; coef = 8'hAA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_out", 32'(out), 32'd0);
    check("midrun_rst_ready", 32'(in_ready), 32'd1);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    run_one(16'hC001, 8'h7F, 0);

    // Reset while DONE holds an unconsumed result.
    in = 16'h7000; coef = 8'hF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("done_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("done_rst_valid", 32'(out_valid), 32'd0);
    check("done_rst_out", 32'(out), 32'd0);
    check("done_rst_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < 40; k++)
      run_one(16'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csd_serial_scaler_16bit.md
Name: csd_serial_scaler_16bit

Overview:
- Bit-serial fractional constant multiplier for the 16-bit signed datapath.
- Computes out = floor(in × coef / 2^COEF_BITS) by iterating an arithmetic-right-shift-by-one and add step, taking one coefficient bit per cycle, LSB first.
- Sits upstream of the fixed shift stages.
- Produces scaled 16-bit two's-complement samples under a valid/ready handshake.

Parameters:
- WIDTH, 16, data width (two's complement).
- COEF_BITS, 8, fractional coefficient width. Also the number of iteration cycles.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > COEF_BITS.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  signed sample, captured on an input handshake.
- coef  input  COEF_BITS  unsigned fractional coefficient (Q0.COEF_BITS), captured with in.
- in_valid  input  1  in/coef valid.
- in_ready  output  1  block can accept a sample.
- out  output  WIDTH  signed scaled result.
- out_valid  output  1  out holds a result.
- out_ready  input  1  downstream accepts out.
- busy  output  1  high in RUN state.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, busy=0, accumulator=0, counter=0. Reset overrides everything, including mid-RUN or while DONE is holding an unconsumed result. That result is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch x<=in, c<=coef, acc<=0, cnt<=0, go to RUN.
  - RUN: in_ready=0, busy=1. Each cycle:
    - sum = sign-extend(acc) to WIDTH+1 bits, plus (c[cnt] ? sign-extend(x) : 0).
    - acc <= sum[WIDTH:1] (arithmetic shift right by 1).
    - cnt <= cnt+1.
    - After the step with cnt==COEF_BITS-1, go to DONE.
  - DONE: out=acc, out_valid=1, in_ready=0. On out_valid&out_ready, out_valid<=0 and go to IDLE.
- Latency: the handshake in cycle T gives out_valid=1 in cycle T+1+COEF_BITS, i.e. T+9 by default.
- Throughput: one result per COEF_BITS+2 cycles minimum. in_ready is low from the accept cycle+1 until the cycle after out is consumed. No overlap, no skid buffer.
- Arithmetic:
  - |acc| ≤ |x| always, so the WIDTH+1 bit sum never overflows.
  - The result is exact floor(x·coef/2^COEF_BITS), rounding toward −∞.
  - coef=0 gives 0.
  - x=−2^(WIDTH−1) with coef=2^COEF_BITS−1 stays in range.
- out holds its value while out_valid is high and out_ready is low. in/coef changes during RUN or DONE are ignored.
- in_valid asserted while in_ready=0 has no effect. The source must hold in_valid until accepted.
- out_ready high in IDLE or RUN has no effect.
- Simultaneous events: in DONE, out_ready high consumes the result. in_ready rises the next cycle (IDLE), so there is no same-cycle re-accept.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - WIDTH and COEF_BITS defaults
  - a function sra1_add(acc, x, en) returning the WIDTH-bit shifted sum.
- One natural sub-module: serial_shift_add_step. It is a combinational WIDTH+1 bit adder plus arithmetic right shift by 1, instantiated once in the RUN datapath.
- FSM, counter and handshake stay in the top module.

Test Plan:
- Reset, then in=16'h4000, coef=8'h80, in_valid pulse at T → out_valid at T+9, out=16'h2000; with out_ready held high, in_ready=1 at T+10.
- in=16'h7FFF, coef=8'hFF → out=16'h7F7F (32639).
- in=16'h8000, coef=8'h80 → out=16'hC000. Then in=16'hFFFF, coef=8'hFF → out=16'hFFFF (floor of −0.996).
- coef=8'h00 with in=16'h1234 → out=16'h0000 after 9 cycles.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: out and out_valid stay stable, in_ready=0, and a new in_valid is ignored.
  - Release out_ready: one transfer, then accept of the next sample.
- Assert rst in the 4th RUN cycle → the next cycle shows IDLE, out_valid=0, out=0, in_ready=1. A fresh sample then completes correctly.
